// File: rtl/axis_processor_arbiter.sv
// axis_processor_arbiter
// Time-shares one AXI-Stream processor between NUM_REQ requesters.
// Session: IDLE (round-robin pick) -> CLEAR (processor held in reset)
// -> STREAM (owner's packet forwarded) -> DRAIN (wait for output to go quiet).
module axis_processor_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INP_WIDTH    = 8,
  parameter int OUT_WIDTH    = 8,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           arstn,
  input  logic [NUM_REQ*INP_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_REQ-1:0]             s_axis_tvalid,
  input  logic [NUM_REQ-1:0]             s_axis_tlast,
  output logic [NUM_REQ-1:0]             s_axis_tready,
  output logic [NUM_REQ*OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [NUM_REQ-1:0]             m_axis_tvalid,
  input  logic [NUM_REQ-1:0]             m_axis_tready,
  output logic [INP_WIDTH-1:0]           p_s_axis_tdata,
  output logic                           p_s_axis_tvalid,
  input  logic                           p_s_axis_tready,
  input  logic [OUT_WIDTH-1:0]           p_m_axis_tdata,
  input  logic                           p_m_axis_tvalid,
  output logic                           p_m_axis_tready,
  output logic                           proc_arstn,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES + 1) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr_ptr;
  logic [CW-1:0]      r_clr_cnt;
  logic [DW-1:0]      r_idle_cnt;
  logic               r_proc_arstn;

  logic               w_req_any;
  logic [IW-1:0]      w_pick;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic               w_stream;
  logic               w_fwd_out;
  logic               w_own_vld;
  logic               w_own_last;
  logic               w_own_mready;
  logic [INP_WIDTH-1:0] w_own_data;
  logic               w_last_acc;
  logic [IW-1:0]      w_next_ptr;

  // Round-robin pick: first valid requester scanning upward from r_rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    w_req_any = 1'b0;
    w_pick    = '0;
    w_pick_oh = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_req_any && s_axis_tvalid[idx]) begin
        w_req_any = 1'b1;
        w_pick    = IW'(idx);
      end
    end
    if (w_req_any) w_pick_oh[w_pick] = 1'b1;
  end

  // Select the owner's input-side signals; constant slice indices keep the mux clean.
  always_comb begin
    w_own_vld    = 1'b0;
    w_own_last   = 1'b0;
    w_own_mready = 1'b0;
    w_own_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_vld    = s_axis_tvalid[i];
        w_own_last   = s_axis_tlast[i];
        w_own_mready = m_axis_tready[i];
        w_own_data   = s_axis_tdata[i*INP_WIDTH +: INP_WIDTH];
      end
    end
  end

  assign w_stream   = (r_state == S_STREAM);
  assign w_fwd_out  = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_last_acc = w_stream && w_own_vld && p_s_axis_tready && w_own_last;
  assign w_next_ptr = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  // Input path: only the owner talks to the processor, and only while streaming.
  // Valid depends on state and the requester alone, never on the processor's ready.
  assign p_s_axis_tvalid = w_stream && w_own_vld;
  assign p_s_axis_tdata  = w_stream ? w_own_data : '0;
  assign s_axis_tready   = (w_stream && p_s_axis_tready) ? r_grant : '0;

  // Output path: data fans out to every slice, the valid bit steers it to the owner.
  assign m_axis_tdata    = {NUM_REQ{p_m_axis_tdata}};
  assign m_axis_tvalid   = (w_fwd_out && p_m_axis_tvalid) ? r_grant : '0;
  assign p_m_axis_tready = w_fwd_out && w_own_mready;

  assign grant      = r_grant;
  assign busy       = (r_state != S_IDLE);
  assign proc_arstn = r_proc_arstn;

  // Session FSM: arbitration, processor clear, packet forwarding and drain detection.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_rr_ptr     <= '0;
      r_clr_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_proc_arstn <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_proc_arstn <= 1'b1;
          if (w_req_any) begin
            r_state      <= S_CLEAR;
            r_grant      <= w_pick_oh;
            r_owner      <= w_pick;
            r_clr_cnt    <= '0;
            r_proc_arstn <= 1'b0;
          end
        end
        S_CLEAR: begin
          // Processor reset stays low for CLR_CYCLES full cycles.
          if (r_clr_cnt == CW'(CLR_CYCLES - 1)) begin
            r_state      <= S_STREAM;
            r_proc_arstn <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (w_last_acc) begin
            r_state    <= S_DRAIN;
            r_idle_cnt <= '0;
          end
        end
        S_DRAIN: begin
          // Any output activity (even stalled) restarts the quiet-time count.
          if (p_m_axis_tvalid) begin
            r_idle_cnt <= '0;
          end else if (r_idle_cnt == DW'(DRAIN_CYCLES - 1)) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= w_next_ptr;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_processor_arbiter.sv
// Directed bench for axis_processor_arbiter (NUM_REQ=4, 8-bit beats,
// CLR_CYCLES=4, DRAIN_CYCLES=16).
module tb_axis_processor_arbiter;

  logic        clk;
  logic        arstn;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tvalid;
  logic [3:0]  m_axis_tready;
  logic [7:0]  p_s_axis_tdata;
  logic        p_s_axis_tvalid;
  logic        p_s_axis_tready;
  logic [7:0]  p_m_axis_tdata;
  logic        p_m_axis_tvalid;
  logic        p_m_axis_tready;
  logic        proc_arstn;
  logic [3:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axis_processor_arbiter #(
    .NUM_REQ(4), .INP_WIDTH(8), .OUT_WIDTH(8), .CLR_CYCLES(4), .DRAIN_CYCLES(16)
  ) dut (
    .clk(clk), .arstn(arstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .p_s_axis_tdata(p_s_axis_tdata), .p_s_axis_tvalid(p_s_axis_tvalid),
    .p_s_axis_tready(p_s_axis_tready),
    .p_m_axis_tdata(p_m_axis_tdata), .p_m_axis_tvalid(p_m_axis_tvalid),
    .p_m_axis_tready(p_m_axis_tready),
    .proc_arstn(proc_arstn), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] last;
    logic [7:0] d0;
    logic [3:0] e_grant;
    logic       e_busy;
    logic       e_parstn;
    logic [3:0] e_sready;
    logic       e_psvld;
    logic       e_pmready;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] last,
                              input logic [7:0] d0, input logic [3:0] g,
                              input logic b, input logic pa, input logic [3:0] sr,
                              input logic psv, input logic pmr);
    vec_t v;
    v.vld = vld; v.last = last; v.d0 = d0;
    v.e_grant = g; v.e_busy = b; v.e_parstn = pa;
    v.e_sready = sr; v.e_psvld = psv; v.e_pmready = pmr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string t, input logic [3:0] g, input logic b,
                          input logic pa, input logic [3:0] sr, input logic psv,
                          input logic pmr, input logic [3:0] mv);
    chk({t, ".grant"}, 32'(grant), 32'(g));
    chk({t, ".busy"}, 32'(busy), 32'(b));
    chk({t, ".proc_arstn"}, 32'(proc_arstn), 32'(pa));
    chk({t, ".s_tready"}, 32'(s_axis_tready), 32'(sr));
    chk({t, ".p_s_tvalid"}, 32'(p_s_axis_tvalid), 32'(psv));
    chk({t, ".p_m_tready"}, 32'(p_m_axis_tready), 32'(pmr));
    chk({t, ".m_tvalid"}, 32'(m_axis_tvalid), 32'(mv));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_axis_tvalid   = '0;
    s_axis_tlast    = '0;
    s_axis_tdata    = '0;
    p_s_axis_tready = 1'b1;
    p_m_axis_tdata  = '0;
    p_m_axis_tvalid = 1'b0;
    m_axis_tready   = '1;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    nxt();
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq[$];
    logic [3:0] exp_seq[5];
    logic [3:0] prev;
    logic [31:0] wdata;
    idle_inputs();
    arstn = 1'b0;

    // ---- 1: reset with every requester valid ----
    s_axis_tvalid   = 4'hF;
    s_axis_tdata    = 32'h44332211;
    p_m_axis_tvalid = 1'b1;
    do_reset();
    @(negedge clk);
    chk_outs("t1_rst", 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    arstn = 1'b1;
    nxt();
    @(negedge clk);
    chk_outs("t1_first", 4'b0001, 1, 0, 4'b0000, 0, 0, 4'b0000);

    // ---- 2 + 6: table-driven session for requester 0, requester 3 parked on 0xFF ----
    tbl.push_back(mk(4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b1101, 4'b0000, 8'h11, 4'b0000, 0, 1, 4'b0000, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(4'b1101, 4'b0000, 8'h11, 4'b0001, 1, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b1101, 4'b0000, 8'h11, 4'b0001, 1, 1, 4'b0001, 1, 1));
    tbl.push_back(mk(4'b1101, 4'b0000, 8'h22, 4'b0001, 1, 1, 4'b0001, 1, 1));
    tbl.push_back(mk(4'b1101, 4'b0001, 8'h33, 4'b0001, 1, 1, 4'b0001, 1, 1));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(4'b1100, 4'b0000, 8'h00, 4'b0001, 1, 1, 4'b0000, 0, 1));
    tbl.push_back(mk(4'b1100, 4'b0000, 8'h00, 4'b0000, 0, 1, 4'b0000, 0, 0));
    tbl.push_back(mk(4'b1100, 4'b0000, 8'h00, 4'b0100, 1, 0, 4'b0000, 0, 0));

    idle_inputs();
    do_reset();
    arstn = 1'b1;
    for (int r = 0; r < tbl.size(); r++) begin
      s_axis_tvalid = tbl[r].vld;
      s_axis_tlast  = tbl[r].last;
      wdata         = {8'hFF, 8'h44, 8'h00, tbl[r].d0};
      s_axis_tdata  = wdata;
      @(negedge clk);
      chk_outs($sformatf("t2_row%0d", r), tbl[r].e_grant, tbl[r].e_busy, tbl[r].e_parstn,
               tbl[r].e_sready, tbl[r].e_psvld, tbl[r].e_pmready, 4'b0000);
      if (tbl[r].e_psvld)
        chk($sformatf("t2_row%0d.p_s_tdata", r), 32'(p_s_axis_tdata), 32'(tbl[r].d0));
      chk($sformatf("t6_row%0d.p_s_tdata_is_FF", r), 32'(p_s_axis_tdata == 8'hFF), 32'd0);
      nxt();
    end

    // ---- 3: stalled output during DRAIN, single-beat packet on first STREAM cycle ----
    idle_inputs();
    m_axis_tready = 4'b1110;
    s_axis_tvalid = 4'b0001;
    s_axis_tlast  = 4'b0001;
    s_axis_tdata  = 32'h000000A0;
    do_reset();
    arstn = 1'b1;
    repeat (5) nxt();
    @(negedge clk);
    chk_outs("t3_stream", 4'b0001, 1, 1, 4'b0001, 1, 0, 4'b0000);
    chk("t3.p_s_tdata", 32'(p_s_axis_tdata), 32'hA0);
    nxt();
    s_axis_tvalid = 4'b0000;
    repeat (10) nxt();
    @(negedge clk);
    chk("t3.busy_after_10_idle", 32'(busy), 32'd1);
    p_m_axis_tvalid = 1'b1;
    p_m_axis_tdata  = 8'hA5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("t3_stall%0d.p_m_tready", c), 32'(p_m_axis_tready), 32'd0);
      chk($sformatf("t3_stall%0d.m_tvalid", c), 32'(m_axis_tvalid), 32'b0001);
      chk($sformatf("t3_stall%0d.busy", c), 32'(busy), 32'd1);
      nxt();
    end
    m_axis_tready = 4'b0001;
    @(negedge clk);
    chk("t3_accept.p_m_tready", 32'(p_m_axis_tready), 32'd1);
    chk("t3_accept.m_tvalid", 32'(m_axis_tvalid), 32'b0001);
    chk("t3_accept.m_tdata", m_axis_tdata, 32'hA5A5A5A5);
    nxt();
    p_m_axis_tvalid = 1'b0;
    repeat (15) nxt();
    @(negedge clk);
    chk("t3_idle15.busy", 32'(busy), 32'd1);
    chk("t3_idle15.grant", 32'(grant), 32'b0001);
    nxt();
    @(negedge clk);
    chk("t3_idle16.busy", 32'(busy), 32'd0);
    chk("t3_idle16.grant", 32'(grant), 32'b0000);

    // ---- 4: continuous contention, single-beat packets ----
    idle_inputs();
    s_axis_tvalid = 4'hF;
    s_axis_tlast  = 4'hF;
    do_reset();
    arstn = 1'b1;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev = 4'b0000;
    for (int c = 0; c < 400 && seq.size() < 5; c++) begin
      @(negedge clk);
      if (prev == 4'b0000 && grant != 4'b0000) seq.push_back(grant);
      prev = grant;
    end
    chk("t4.sessions_seen", 32'(seq.size()), 32'd5);
    for (int i = 0; i < seq.size() && i < 5; i++)
      chk($sformatf("t4.grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));

    // ---- 5: reset asserted mid-packet ----
    idle_inputs();
    s_axis_tvalid = 4'b0001;
    s_axis_tdata  = 32'h00000011;
    do_reset();
    arstn = 1'b1;
    repeat (5) nxt();
    @(negedge clk);
    chk("t5_beat1.p_s_tvalid", 32'(p_s_axis_tvalid), 32'd1);
    chk("t5_beat1.p_s_tdata", 32'(p_s_axis_tdata), 32'h11);
    chk("t5_beat1.s_tready", 32'(s_axis_tready), 32'b0001);
    nxt();
    s_axis_tdata = 32'h00000022;
    arstn = 1'b0;
    nxt();
    @(negedge clk);
    chk_outs("t5_rst", 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);
    nxt();
    arstn = 1'b1;
    @(negedge clk);
    chk_outs("t5_release", 4'b0000, 0, 0, 4'b0000, 0, 0, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
